// File: rtl/ec_mult_scheduler.sv
// ec_mult_scheduler
// Request front-end for the point multiplier. Jobs (point, scalar, tag) are
// buffered in a small FIFO and handed to the multiplier one at a time over a
// start/done handshake. Each result is returned with its tag on a
// valid/ready response port. A scalar of zero bypasses the multiplier and
// returns the point at infinity (encoded as 0). A job whose done never
// arrives is abandoned after TIMEOUT cycles and reported with rsp_timeout_o.
module ec_mult_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned TIMEOUT = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // request port
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [13:0]              req_point_i,
  input  logic [6:0]               req_scalar_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  // multiplier interface
  output logic                     mul_start_o,
  output logic [13:0]              mul_point_o,
  output logic [6:0]               mul_scalar_o,
  input  logic [13:0]              mul_result_i,
  input  logic                     mul_done_i,
  // response port
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [13:0]              rsp_point_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic                     rsp_timeout_o,
  // status
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;
  localparam int unsigned ENT_W = 14 + 7 + TAG_W;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_EMPTY = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE   = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BLANK = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [DEPTH];

  state_e           state_q,       state_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [LVL_W-1:0] level_q,       level_d;
  logic [TMR_W-1:0] timer_q,       timer_d;

  logic [13:0]      job_point_q,   job_point_d;
  logic [6:0]       job_scalar_q,  job_scalar_d;
  logic [TAG_W-1:0] job_tag_q,     job_tag_d;

  logic [13:0]      rsp_point_q,   rsp_point_d;
  logic [TAG_W-1:0] rsp_tag_q,     rsp_tag_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  // Output flags are registered from the next-state values so that every
  // port is driven straight from a flop.
  logic             rsp_valid_q,   rsp_valid_d;
  logic             mul_start_q,   mul_start_d;
  logic             busy_q,        busy_d;
  logic             req_ready_q,   req_ready_d;

  // FIFO handshake strobes
  logic             push_s;
  logic             pop_s;

  // Head-of-FIFO entry, unpacked
  logic [ENT_W-1:0] head_s;
  logic [13:0]      head_point_s;
  logic [6:0]       head_scalar_s;
  logic [TAG_W-1:0] head_tag_s;

  assign head_s = mem_q[rd_ptr_q];
  assign {head_point_s, head_scalar_s, head_tag_s} = head_s;

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM transitions, FIFO bookkeeping and output staging
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    timer_d       = TMR_ZERO;
    job_point_d   = job_point_q;
    job_scalar_d  = job_scalar_q;
    job_tag_d     = job_tag_q;
    rsp_point_d   = rsp_point_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_timeout_d = rsp_timeout_q;
    pop_s         = 1'b0;

    // req_ready_q reflects the registered level, so a full FIFO refuses a
    // push even in the cycle it is being popped.
    push_s = req_valid_i && req_ready_q;

    case (state_q)
      S_IDLE: begin
        if (level_q != LVL_EMPTY) begin
          pop_s = 1'b1;
          if (head_scalar_s != 7'd0) begin
            // Multiplier inputs only change when a real job is issued.
            job_point_d  = head_point_s;
            job_scalar_d = head_scalar_s;
            job_tag_d    = head_tag_s;
            state_d      = S_ISSUE;
          end else begin
            // k == 0 gives the point at infinity without using the multiplier.
            rsp_point_d   = 14'd0;
            rsp_tag_d     = head_tag_s;
            rsp_timeout_d = 1'b0;
            state_d       = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        state_d = S_BLANK;
      end

      S_BLANK: begin
        // mul_done may still be high from the previous job for this cycle.
        state_d = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_q + TMR_ONE;
        if (mul_done_i) begin
          // Done has priority over a coincident timeout.
          rsp_point_d   = mul_result_i;
          rsp_tag_d     = job_tag_q;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          rsp_point_d   = 14'd0;
          rsp_tag_d     = job_tag_q;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s && !pop_s) begin
      level_d = level_q + LVL_ONE;
    end else if (!push_s && pop_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end

    mul_start_d = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE) || (level_d != LVL_EMPTY);
    req_ready_d = (level_d != LVL_FULL);
  end

  // ---------------------------------------------------------------------------
  // State register with synchronous active-low reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      level_q       <= LVL_EMPTY;
      timer_q       <= TMR_ZERO;
      job_point_q   <= 14'd0;
      job_scalar_q  <= 7'd0;
      job_tag_q     <= {TAG_W{1'b0}};
      rsp_point_q   <= 14'd0;
      rsp_tag_q     <= {TAG_W{1'b0}};
      rsp_timeout_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      mul_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      timer_q       <= timer_d;
      job_point_q   <= job_point_d;
      job_scalar_q  <= job_scalar_d;
      job_tag_q     <= job_tag_d;
      rsp_point_q   <= rsp_point_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_valid_q   <= rsp_valid_d;
      mul_start_q   <= mul_start_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage write port (contents need no reset; pointers define validity)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_q[wr_ptr_q] <= {req_point_i, req_scalar_i, req_tag_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Output ports
  // ---------------------------------------------------------------------------
  assign req_ready_o   = req_ready_q;
  assign mul_start_o   = mul_start_q;
  assign mul_point_o   = job_point_q;
  assign mul_scalar_o  = job_scalar_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_point_o   = rsp_point_q;
  assign rsp_tag_o     = rsp_tag_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = busy_q;
  assign fifo_level_o  = level_q;

endmodule
